jtdd_snd_out: RTL

JTDD_SND_OUT -- requirements
Module: jtdd_snd_out

---
 rtl/jtdd_pkg.sv | 18 +
 rtl/jtdd_dcrm.sv | 30 +++
 rtl/jtdd_snd_out.sv | 106 ++++++++++
 3 files changed

// File: rtl/jtdd_pkg.sv
// rtl/jtdd_pkg.sv - shared widths, output limits and fxlevel-to-gain mapping for the jtdd sound path
package jtdd_pkg;

    localparam int SND_W = 16;
    localparam int HP_W  = 17;
    localparam int ACC_W = 24;
    localparam int S2_W  = 20;

    localparam logic signed [S2_W-1:0] OUT_MAX  = 20'sd32767;
    localparam logic signed [S2_W-1:0] OUT_MIN  = -20'sd32768;
    localparam logic        [7:0]      CLIP_MAX = 8'd255;

    // Gain applied before the >>>1, so 1..4 maps to x0.5 .. x2
    function automatic logic [2:0] fx_gain(input logic [1:0] fx);
        return {1'b0, fx} + 3'd1;
    endfunction

endpackage

// File: rtl/jtdd_dcrm.sv
// rtl/jtdd_dcrm.sv - leaky-integrator DC removal; dout is combinational, the accumulator steps on valid
module jtdd_dcrm
    import jtdd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic signed [SND_W-1:0] din,
    output logic signed [HP_W-1:0]  dout
);

    logic signed [ACC_W-1:0] dc_acc_q, dc_acc_d;

    always_comb begin
        dout     = {din[SND_W-1], din} - {dc_acc_q[ACC_W-1], dc_acc_q[ACC_W-1:8]};
        dc_acc_d = dc_acc_q;
        if (valid) begin
            dc_acc_d = dc_acc_q + {{(ACC_W-HP_W){dout[HP_W-1]}}, dout};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_acc_q <= '0;
        end else begin
            dc_acc_q <= dc_acc_d;
        end
    end

endmodule

// File: rtl/jtdd_snd_out.sv
// rtl/jtdd_snd_out.sv - 3-stage sound output conditioner; JTDD_SND_DCRM_EN enables DC removal in S1
module jtdd_snd_out
    import jtdd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [SND_W-1:0] snd_in,
    input  logic                    sample_in,
    input  logic [1:0]              fxlevel,
    input  logic                    enable,
    input  logic                    clip_clr,
    output logic signed [SND_W-1:0] snd_out,
    output logic                    sample_out,
    output logic [7:0]              clip_cnt
);

    logic signed [HP_W-1:0]  hp_w;
    logic                    s1_v_q, s1_v_d;
    logic signed [HP_W-1:0]  s1_hp_q, s1_hp_d;
    logic                    s2_v_q, s2_v_d;
    logic signed [SND_W-1:0] s2_val_q, s2_val_d;
    logic                    s2_clip_q, s2_clip_d;
    logic signed [SND_W-1:0] snd_out_q, snd_out_d;
    logic                    sample_out_q, sample_out_d;
    logic [7:0]              clip_cnt_q, clip_cnt_d;
    logic signed [S2_W-1:0]  hp_ext, gain_ext, prod_full, prod;

`ifdef JTDD_SND_DCRM_EN
    jtdd_dcrm u_dcrm (
        .clk   (clk),
        .rst   (rst),
        .valid (sample_in),
        .din   (snd_in),
        .dout  (hp_w)
    );
`else
    always_comb hp_w = {snd_in[SND_W-1], snd_in};
`endif

    always_comb begin
        s1_v_d  = sample_in;
        s1_hp_d = sample_in ? hp_w : s1_hp_q;

        // fxlevel is read here, in the token's S2 cycle
        hp_ext    = {{(S2_W-HP_W){s1_hp_q[HP_W-1]}}, s1_hp_q};
        gain_ext  = {{(S2_W-3){1'b0}}, fx_gain(fxlevel)};
        prod_full = hp_ext * gain_ext;
        prod      = prod_full >>> 1;

        s2_v_d    = s1_v_q;
        s2_val_d  = s2_val_q;
        s2_clip_d = s2_clip_q;
        if (s1_v_q) begin
            s2_clip_d = 1'b1;
            if (prod > OUT_MAX) begin
                s2_val_d = OUT_MAX[SND_W-1:0];
            end else if (prod < OUT_MIN) begin
                s2_val_d = OUT_MIN[SND_W-1:0];
            end else begin
                s2_val_d  = prod[SND_W-1:0];
                s2_clip_d = 1'b0;
            end
        end

        sample_out_d = s2_v_q;
        snd_out_d    = snd_out_q;
        if (s2_v_q) begin
            snd_out_d = enable ? s2_val_q : '0;
        end

        // A clear wins over a same-cycle increment
        clip_cnt_d = clip_cnt_q;
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (s2_v_q && s2_clip_q && clip_cnt_q != CLIP_MAX) begin
            clip_cnt_d = clip_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s1_hp_q      <= '0;
            s2_v_q       <= 1'b0;
            s2_val_q     <= '0;
            s2_clip_q    <= 1'b0;
            snd_out_q    <= '0;
            sample_out_q <= 1'b0;
            clip_cnt_q   <= '0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_hp_q      <= s1_hp_d;
            s2_v_q       <= s2_v_d;
            s2_val_q     <= s2_val_d;
            s2_clip_q    <= s2_clip_d;
            snd_out_q    <= snd_out_d;
            sample_out_q <= sample_out_d;
            clip_cnt_q   <= clip_cnt_d;
        end
    end

    assign snd_out    = snd_out_q;
    assign sample_out = sample_out_q;
    assign clip_cnt   = clip_cnt_q;

endmodule
